// File: rtl/m2s_dma_pkg.sv
// Shared types and constants for the memory-to-stream read engine.
// Beat geometry, FSM states, descriptor bundle and length helpers.
package m2s_dma_pkg;

    localparam int BEAT_BYTES  = 64;
    localparam int BEAT_SHIFT  = 6;
    localparam int BURST_W     = 3;
    localparam int DESC_ADDR_W = 48;
    localparam int DESC_LEN_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } m2s_state_e;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0] address;
        logic [DESC_LEN_W-1:0]  length;
    } m2s_desc_t;

    // Number of 64-byte beats covering len bytes (rounded up).
    function automatic logic [DESC_LEN_W-1:0] beats_of(
        input logic [DESC_LEN_W-1:0] len
    );
        return (len >> BEAT_SHIFT)
             + DESC_LEN_W'(|len[BEAT_SHIFT-1:0]);
    endfunction

    // Unused bytes in the last beat; 0 when len is a beat multiple.
    function automatic logic [BEAT_SHIFT-1:0] eop_empty_of(
        input logic [DESC_LEN_W-1:0] len
    );
        return '0 - len[BEAT_SHIFT-1:0];
    endfunction

endpackage

// File: rtl/mem_to_stream_read_engine_if.sv
// Descriptor, Avalon-MM read master and Avalon-ST source bundle.
// master = engine side, slave = memory/sink/descriptor-source side.
interface mem_to_stream_read_engine_if #(
    parameter int ADDR_W  = 48,
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int LEN_W   = 32
);
    import m2s_dma_pkg::*;

    logic               desc_valid;
    logic               desc_ready;
    logic [ADDR_W-1:0]  desc_address;
    logic [LEN_W-1:0]   desc_length;

    logic [ADDR_W-1:0]  mem_read_address;
    logic               mem_read_read;
    logic [BURST_W-1:0] mem_read_burstcount;
    logic               mem_read_waitrequest;
    logic [DATA_W-1:0]  mem_read_readdata;
    logic               mem_read_readdatavalid;

    logic [DATA_W-1:0]  m2s_st_source_data;
    logic               m2s_st_source_valid;
    logic               m2s_st_source_ready;
    logic               m2s_st_source_startofpacket;
    logic               m2s_st_source_endofpacket;
    logic [EMPTY_W-1:0] m2s_st_source_empty;

    modport master (
        input  desc_valid, desc_address, desc_length,
        output desc_ready,
        output mem_read_address, mem_read_read,
        output mem_read_burstcount,
        input  mem_read_waitrequest, mem_read_readdata,
        input  mem_read_readdatavalid,
        output m2s_st_source_data, m2s_st_source_valid,
        output m2s_st_source_startofpacket,
        output m2s_st_source_endofpacket,
        output m2s_st_source_empty,
        input  m2s_st_source_ready
    );

    modport slave (
        output desc_valid, desc_address, desc_length,
        input  desc_ready,
        input  mem_read_address, mem_read_read,
        input  mem_read_burstcount,
        output mem_read_waitrequest, mem_read_readdata,
        output mem_read_readdatavalid,
        input  m2s_st_source_data, m2s_st_source_valid,
        input  m2s_st_source_startofpacket,
        input  m2s_st_source_endofpacket,
        input  m2s_st_source_empty,
        output m2s_st_source_ready
    );

endinterface

// File: rtl/mem_to_stream_read_engine_fifo.sv
// First-word-fall-through return-data FIFO with occupancy count.
// Head word is visible on data_o whenever empty_o is low.
module m2s_fwft_fifo #(
    parameter int W     = 512,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_pop;

    assign do_pop  = pop_i && !empty_o;
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    // Storage array, written at the tail pointer.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(push_i && cnt_q == CNT_W'(DEPTH))
    );

endmodule

// File: rtl/mem_to_stream_read_engine.sv
// Memory-to-stream mover: burst reads replayed as an SOP/EOP packet.
// Credits (fifo + outstanding + burst) bound in-flight data to the FIFO.
module mem_to_stream_read_engine
    import m2s_dma_pkg::*;
#(
    parameter int ADDR_W     = DESC_ADDR_W,
    parameter int DATA_W     = 512,
    parameter int EMPTY_W    = 6,
    parameter int MAX_BURST  = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = DESC_LEN_W
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    mem_to_stream_read_engine_if.master bus,
    input  logic irq_clear,
    output logic m2s_irq_irq,
    output logic busy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam int OFF_W = $clog2(MAX_BURST);

    m2s_state_e         state_q, state_d;
    m2s_desc_t          desc_in;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   left_q, left_d;
    logic [LEN_W-1:0]   total_q, total_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [EMPTY_W-1:0] empty_q, empty_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               read_q, read_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic               eop_seen_q, eop_seen_d;
    logic               irq_q, irq_d;

    logic               desc_acc, rd_acc, rdv_ok;
    logic               out_valid, pop, is_last;
    logic               fifo_empty, can_issue;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [DATA_W-1:0]  fifo_dout;
    logic [BURST_W-1:0] to_bound, burst_c;
    logic [SUM_W-1:0]   credit;

    assign desc_in.address = bus.desc_address;
    assign desc_in.length  = bus.desc_length;

    assign desc_acc  = bus.desc_valid && (state_q == ST_IDLE);
    assign rd_acc    = read_q && !bus.mem_read_waitrequest;
    // Returns with nothing outstanding are stale (pre-reset) and dropped.
    assign rdv_ok    = bus.mem_read_readdatavalid && (outst_q != '0);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && bus.m2s_st_source_ready;
    assign is_last   = (idx_q == total_q - LEN_W'(1));

    assign to_bound  = BURST_W'(MAX_BURST)
                     - BURST_W'(addr_q[BEAT_SHIFT +: OFF_W]);
    assign burst_c   = (left_q < LEN_W'(to_bound))
                     ? left_q[BURST_W-1:0] : to_bound;
    assign credit    = SUM_W'(fifo_cnt) + SUM_W'(outst_q)
                     + SUM_W'(burst_c);
    assign can_issue = (state_q == ST_ISSUE) && !read_q
                     && (left_q != '0)
                     && (credit <= SUM_W'(FIFO_DEPTH));

    m2s_fwft_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .push_i  (rdv_ok),
        .data_i  (bus.mem_read_readdata),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Next-state for the FSM, burst issue, credits and packet framing.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        left_d     = left_q;
        total_d    = total_q;
        idx_d      = idx_q;
        empty_d    = empty_q;
        burst_d    = burst_q;
        read_d     = read_q;
        eop_seen_d = eop_seen_q;
        outst_d    = outst_q
                   + (rd_acc ? CNT_W'(burst_q) : '0)
                   - CNT_W'(rdv_ok);
        irq_d      = irq_q;

        unique case (state_q)
            ST_IDLE: begin
                if (desc_acc) begin
                    state_d = (desc_in.length == '0)
                            ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rd_acc && left_q == LEN_W'(burst_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outst_q == '0 && fifo_empty && eop_seen_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (can_issue) begin
            read_d  = 1'b1;
            burst_d = burst_c;
        end
        if (rd_acc) begin
            read_d = 1'b0;
            addr_d = addr_q + (ADDR_W'(burst_q) << BEAT_SHIFT);
            left_d = left_q - LEN_W'(burst_q);
        end
        if (pop) begin
            idx_d = idx_q + LEN_W'(1);
            if (is_last) eop_seen_d = 1'b1;
        end
        if (desc_acc) begin
            addr_d     = desc_in.address;
            left_d     = LEN_W'(beats_of(desc_in.length));
            total_d    = LEN_W'(beats_of(desc_in.length));
            empty_d    = EMPTY_W'(eop_empty_of(desc_in.length));
            idx_d      = '0;
            eop_seen_d = 1'b0;
        end

        if (state_q == ST_DONE) begin
            irq_d = 1'b1;
        end else if (irq_clear) begin
            irq_d = 1'b0;
        end
    end

    // State registers; reset abandons any transfer in flight.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            left_q     <= '0;
            total_q    <= '0;
            idx_q      <= '0;
            empty_q    <= '0;
            burst_q    <= '0;
            read_q     <= 1'b0;
            outst_q    <= '0;
            eop_seen_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            total_q    <= total_d;
            idx_q      <= idx_d;
            empty_q    <= empty_d;
            burst_q    <= burst_d;
            read_q     <= read_d;
            outst_q    <= outst_d;
            eop_seen_q <= eop_seen_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.desc_ready          = (state_q == ST_IDLE);
    assign bus.mem_read_address    = addr_q;
    assign bus.mem_read_read       = read_q;
    assign bus.mem_read_burstcount = burst_q;

    assign bus.m2s_st_source_valid = out_valid;
    assign bus.m2s_st_source_data  = out_valid ? fifo_dout : '0;
    assign bus.m2s_st_source_startofpacket =
        out_valid && (idx_q == '0);
    assign bus.m2s_st_source_endofpacket = out_valid && is_last;
    assign bus.m2s_st_source_empty =
        (out_valid && is_last) ? empty_q : '0;

    assign m2s_irq_irq = irq_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_to_stream_read_engine.sv
// Scoreboard bench for mem_to_stream_read_engine.
// Memory word at byte address a is {8{a, 16'hC0DE}}.
module tb_mem_to_stream_read_engine;
    import m2s_dma_pkg::*;

    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
    } beat_t;

    typedef struct packed {
        logic [47:0] addr;
        logic [2:0]  bc;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq_clear = 1'b0;
    logic irq;
    logic busy;

    mem_to_stream_read_engine_if bus ();

    mem_to_stream_read_engine dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus),
        .irq_clear     (irq_clear),
        .m2s_irq_irq   (irq),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    beat_t       exp_beats[$];
    req_t        exp_reqs[$];
    logic [47:0] ret_q[$];

    int stall_cnt = 0;
    bit rdv_en = 1'b1;
    bit rdv_bursty = 1'b0;
    bit rdy_mode = 1'b0;
    int acc_beats = 0;
    int pop_beats = 0;
    int max_infl = 0;

    function automatic logic [511:0] pat(input logic [47:0] a);
        return {8{a, 16'hC0DE}};
    endfunction

    function automatic logic [64:0] outs();
        return {bus.desc_ready, bus.mem_read_read,
                bus.mem_read_burstcount, bus.mem_read_address,
                bus.m2s_st_source_valid,
                bus.m2s_st_source_startofpacket,
                bus.m2s_st_source_endofpacket,
                bus.m2s_st_source_empty,
                |bus.m2s_st_source_data, irq, busy};
    endfunction

    task automatic chk(input string nm,
                       input logic [575:0] act,
                       input logic [575:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic push_req(input logic [47:0] a,
                            input logic [2:0] bc);
        req_t r;
        r.addr = a;
        r.bc = bc;
        exp_reqs.push_back(r);
    endtask

    task automatic push_beat(input logic [47:0] a, input bit s,
                             input bit e, input logic [5:0] emp);
        beat_t b;
        b.data = pat(a);
        b.sop = s;
        b.eop = e;
        b.empty = emp;
        exp_beats.push_back(b);
    endtask

    // Memory slave: returns data first, then samples this cycle's request.
    initial begin : slave
        int cyc;
        bit stalling;
        logic [51:0] held;
        req_t r;
        cyc = 0;
        stalling = 1'b0;
        held = '0;
        bus.mem_read_waitrequest = 1'b0;
        bus.mem_read_readdatavalid = 1'b0;
        bus.mem_read_readdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ret_q.size() > 0 && rdv_en
                && (!rdv_bursty || (cyc % 8) < 5)) begin
                bus.mem_read_readdatavalid = 1'b1;
                bus.mem_read_readdata = pat(ret_q.pop_front());
            end else begin
                bus.mem_read_readdatavalid = 1'b0;
            end
            if (bus.mem_read_read && rst_n) begin
                if (stalling) begin
                    chk("wait_hold", {bus.mem_read_read,
                        bus.mem_read_address,
                        bus.mem_read_burstcount}, held);
                end
                if (stall_cnt > 0) begin
                    held = {bus.mem_read_read,
                            bus.mem_read_address,
                            bus.mem_read_burstcount};
                    stalling = 1'b1;
                    bus.mem_read_waitrequest = 1'b1;
                    stall_cnt--;
                end else begin
                    stalling = 1'b0;
                    bus.mem_read_waitrequest = 1'b0;
                    chk("read_expected", 576'(exp_reqs.size() != 0),
                        576'(1));
                    if (exp_reqs.size() != 0) begin
                        r = exp_reqs.pop_front();
                        chk("burst", {bus.mem_read_address,
                            bus.mem_read_burstcount}, r);
                    end
                    for (int i = 0; i < int'(bus.mem_read_burstcount);
                         i++) begin
                        ret_q.push_back(bus.mem_read_address
                                        + 48'(64 * i));
                    end
                    acc_beats += int'(bus.mem_read_burstcount);
                    if (acc_beats - pop_beats > max_infl) begin
                        max_infl = acc_beats - pop_beats;
                    end
                end
            end else begin
                if (stalling) begin
                    chk("wait_read_held", 576'(bus.mem_read_read),
                        576'(1));
                end
                stalling = 1'b0;
                bus.mem_read_waitrequest = 1'b0;
            end
        end
    end

    // Stream monitor: drives ready, pops the scoreboard on each transfer.
    initial begin : monitor
        int mcyc;
        bit hold_pend;
        beat_t got;
        beat_t held_b;
        mcyc = 0;
        hold_pend = 1'b0;
        held_b = '0;
        bus.m2s_st_source_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.m2s_st_source_ready = rdy_mode ? ((mcyc % 4) == 0)
                                               : 1'b1;
            mcyc++;
            got = {bus.m2s_st_source_data,
                   bus.m2s_st_source_startofpacket,
                   bus.m2s_st_source_endofpacket,
                   bus.m2s_st_source_empty};
            if (hold_pend && bus.m2s_st_source_valid) begin
                chk("st_hold", got, held_b);
            end
            hold_pend = bus.m2s_st_source_valid
                     && !bus.m2s_st_source_ready;
            held_b = got;
            if (bus.m2s_st_source_valid
                && bus.m2s_st_source_ready) begin
                chk("beat_expected", 576'(exp_beats.size() != 0),
                    576'(1));
                if (exp_beats.size() != 0) begin
                    chk("beat", got, exp_beats.pop_front());
                end
                pop_beats++;
            end
        end
    end

    task automatic send_desc(input logic [47:0] a,
                             input logic [31:0] l);
        int n;
        n = 0;
        @(negedge clk);
        bus.desc_valid = 1'b1;
        bus.desc_address = a;
        bus.desc_length = l;
        while (!bus.desc_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("desc_ready", 576'(bus.desc_ready), 576'(1));
        @(posedge clk);
        #1 bus.desc_valid = 1'b0;
    endtask

    task automatic finish_desc();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_time", 576'(n < 3000), 576'(1));
        repeat (3) @(negedge clk);
        chk("beats_left", 576'(exp_beats.size()), 576'(0));
        chk("reqs_left", 576'(exp_reqs.size()), 576'(0));
        chk("irq_ready", {irq, bus.desc_ready, busy}, 3'b110);
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        chk("irq_clear", 576'(irq), 576'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int n;
        bus.desc_valid = 1'b0;
        bus.desc_address = '0;
        bus.desc_length = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), {1'b1, 64'b0});
        rst_n = 1'b1;

        // 256 B aligned: one burst of 4.
        push_req(48'h1000, 3'd4);
        push_beat(48'h1000, 1, 0, 0);
        push_beat(48'h1040, 0, 0, 0);
        push_beat(48'h1080, 0, 0, 0);
        push_beat(48'h10C0, 0, 1, 0);
        send_desc(48'h1000, 32'd256);
        finish_desc();

        // 200 B straddling a 256 B boundary: 1 then 3.
        push_req(48'h10C0, 3'd1);
        push_req(48'h1100, 3'd3);
        push_beat(48'h10C0, 1, 0, 0);
        push_beat(48'h1100, 0, 0, 0);
        push_beat(48'h1140, 0, 0, 0);
        push_beat(48'h1180, 0, 1, 6'd56);
        send_desc(48'h10C0, 32'd200);
        finish_desc();

        // 64 B with 5 stall cycles.
        stall_cnt = 5;
        push_req(48'h2000, 3'd1);
        push_beat(48'h2000, 1, 1, 0);
        send_desc(48'h2000, 32'd64);
        finish_desc();
        chk("stall_used", 576'(stall_cnt), 576'(0));

        // 1 B: single beat, 63 unused bytes.
        push_req(48'h6040, 3'd1);
        push_beat(48'h6040, 1, 1, 6'd63);
        send_desc(48'h6040, 32'd1);
        finish_desc();

        // 4 KiB under sink backpressure and bursty returns.
        rdy_mode = 1'b1;
        rdv_bursty = 1'b1;
        max_infl = 0;
        for (int k = 0; k < 16; k++) begin
            push_req(48'h20000 + 48'(256 * k), 3'd4);
        end
        for (int i = 0; i < 64; i++) begin
            push_beat(48'h20000 + 48'(64 * i), i == 0, i == 63, 0);
        end
        send_desc(48'h20000, 32'd4096);
        finish_desc();
        chk("max_inflight_le16", 576'(max_infl <= 16), 576'(1));
        chk("max_inflight_used", 576'(max_infl > 4), 576'(1));
        rdy_mode = 1'b0;
        rdv_bursty = 1'b0;

        // Zero length; clear held during DONE loses to the set.
        send_desc(48'h4000, 32'd0);
        @(negedge clk);
        chk("len0_done", {busy, irq}, 2'b10);
        irq_clear = 1'b1;
        @(negedge clk);
        chk("len0_irq_set_wins", {irq, busy, bus.desc_ready},
            3'b101);
        @(negedge clk);
        chk("len0_irq_cleared", 576'(irq), 576'(0));
        irq_clear = 1'b0;

        // Reset with 4 beats outstanding, then stale returns.
        rdv_en = 1'b0;
        base = acc_beats;
        push_req(48'h3000, 3'd4);
        send_desc(48'h3000, 32'd256);
        n = 0;
        while (acc_beats - base < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_outstanding", 576'(acc_beats - base), 576'(4));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_outputs", outs(), {1'b1, 64'b0});
        @(negedge clk);
        rst_n = 1'b1;
        rdv_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("stale_drained", 576'(ret_q.size()), 576'(0));
        chk("stale_idle", {bus.desc_ready, busy}, 2'b10);

        // 128 B after reset.
        push_req(48'h5000, 3'd2);
        push_beat(48'h5000, 1, 0, 0);
        push_beat(48'h5040, 0, 1, 0);
        send_desc(48'h5000, 32'd128);
        finish_desc();

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
